// File: rtl/pass_set.sv
// Password programming block for the 4-digit switch/key lock: old code, new code, confirm.
// Optional registered 7-segment status display is enabled with `define PASS_SET_HEX_EN.
module pass_set #(
    parameter int              DIGITS       = 4,
    parameter int              DW           = 4,
    parameter logic [15:0]     DEFAULT_CODE = 16'h1234
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        SW,
    input  logic [1:0]           KEY,
    output logic [DIGITS*DW-1:0] code_o,
    output logic                 code_upd,
    output logic                 busy,
    output logic [0:6]           HEX0,
    output logic [0:6]           HEX1,
    output logic [0:6]           HEX2,
    output logic [0:6]           HEX3
);
    localparam int CW   = DIGITS * DW;
    localparam int CNTW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(DIGITS - 1);

    typedef enum logic [2:0] {OLD, NEW, CONF, OK, ERR} state_t;

    logic [1:0]    key_s1, key_s2, key_d;
    logic [DW-1:0] sw_s1, sw_s2;
    logic          ent_p, can_p;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic [CW-1:0]   ebuf, ebuf_nx, nbuf, nbuf_nx, code_r, code_nx, ins;
    logic            upd_nx;

    // Keys idle high, so the synchronizer resets to "released" to avoid a false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            key_d  <= 2'b11;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            key_d  <= key_s2;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    assign ent_p = key_d[0] & ~key_s2[0];
    assign can_p = key_d[1] & ~key_s2[1];

    always_comb begin
        ins = ebuf;
        ins[CW-1-DW*int'(cnt) -: DW] = sw_s2;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ebuf_nx  = ebuf;
        nbuf_nx  = nbuf;
        code_nx  = code_r;
        upd_nx   = 1'b0;
        case (state)
            OLD, NEW, CONF: begin
                if (can_p) begin
                    cnt_nx   = '0;
                    ebuf_nx  = '0;
                    nbuf_nx  = '0;
                    state_nx = OLD;
                end else if (ent_p) begin
                    if (cnt == LAST) begin
                        cnt_nx  = '0;
                        ebuf_nx = '0;
                        case (state)
                            OLD:  state_nx = (ins == code_r) ? NEW : ERR;
                            NEW: begin
                                nbuf_nx  = ins;
                                state_nx = CONF;
                            end
                            default: begin
                                if (ins == nbuf) begin
                                    code_nx  = nbuf;
                                    upd_nx   = 1'b1;
                                    state_nx = OK;
                                end else begin
                                    state_nx = ERR;
                                end
                            end
                        endcase
                    end else begin
                        cnt_nx  = cnt + 1'b1;
                        ebuf_nx = ins;
                    end
                end
            end
            default: begin
                if (can_p) begin
                    nbuf_nx  = '0;
                    state_nx = OLD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OLD;
            cnt      <= '0;
            ebuf     <= '0;
            nbuf     <= '0;
            code_r   <= CW'(DEFAULT_CODE);
            code_upd <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ebuf     <= ebuf_nx;
            nbuf     <= nbuf_nx;
            code_r   <= code_nx;
            code_upd <= upd_nx;
        end
    end

    assign code_o = code_r;
    assign busy   = (cnt != '0) || (state == NEW) || (state == CONF);

`ifdef PASS_SET_HEX_EN
    localparam logic [0:6] BLANK = 7'b1111111;

    function automatic logic [0:6] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'b0000001;
            4'h1: font = 7'b1001111;
            4'h2: font = 7'b0010010;
            4'h3: font = 7'b0000110;
            4'h4: font = 7'b1001100;
            4'h5: font = 7'b0100100;
            4'h6: font = 7'b0100000;
            4'h7: font = 7'b0001111;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0000100;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b1100000;
            4'hC: font = 7'b0110001;
            4'hD: font = 7'b1000010;
            4'hE: font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
    endfunction

    logic [0:6] h0_nx, h1_nx, h2_nx, h3_nx;

    always_comb begin
        h0_nx = font(4'(sw_s2));
        h1_nx = font(4'(cnt));
        h2_nx = BLANK;
        h3_nx = BLANK;
        case (state)
            OLD:  h3_nx = 7'b1100010;
            NEW:  h3_nx = 7'b1101010;
            CONF: h3_nx = 7'b0110001;
            OK: begin
                h3_nx = 7'b1000010;
                h2_nx = 7'b1100010;
                h1_nx = 7'b1101010;
                h0_nx = 7'b0110000;
            end
            default: begin
                h2_nx = 7'b0110000;
                h1_nx = 7'b1111010;
                h0_nx = 7'b1111010;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HEX0 <= BLANK;
            HEX1 <= BLANK;
            HEX2 <= BLANK;
            HEX3 <= BLANK;
        end else begin
            HEX0 <= h0_nx;
            HEX1 <= h1_nx;
            HEX2 <= h2_nx;
            HEX3 <= h3_nx;
        end
    end
`else
    assign HEX0 = 7'b1111111;
    assign HEX1 = 7'b1111111;
    assign HEX2 = 7'b1111111;
    assign HEX3 = 7'b1111111;
`endif

endmodule

// File: tb/tb_pass_set.sv
// Directed self-checking bench for pass_set (default build, display disabled).
module tb_pass_set;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  SW = 4'h0;
    logic [1:0]  KEY = 2'b11;
    logic [15:0] code_o;
    logic        code_upd, busy;
    logic [0:6]  HEX0, HEX1, HEX2, HEX3;

    int checks = 0;
    int errors = 0;
    int upd_total = 0;

    pass_set dut (
        .clk(clk), .rst_n(rst_n), .SW(SW), .KEY(KEY),
        .code_o(code_o), .code_upd(code_upd), .busy(busy),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (code_upd) upd_total++;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] d);
        SW = d;
        KEY[0] = 1'b0;
        clks(10);
        KEY[0] = 1'b1;
        clks(10);
    endtask

    task automatic code4(input logic [15:0] c);
        digit(c[15:12]);
        digit(c[11:8]);
        digit(c[7:4]);
        digit(c[3:0]);
    endtask

    task automatic cancel();
        KEY[1] = 1'b0;
        clks(10);
        KEY[1] = 1'b1;
        clks(10);
    endtask

    task automatic do_reset();
        KEY = 2'b11;
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(3);
    endtask

    task automatic test_reset();
        int base;
        do_reset();
        base = upd_total;
        clks(5);
        checks++; if (code_o !== 16'h1234) begin errors++; $display("FAIL reset_code got %h exp 1234", code_o); end
        checks++; if (code_upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b exp 0", code_upd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (upd_total != base) begin errors++; $display("FAIL reset_nopulse got %0d exp 0", upd_total - base); end
        checks++; if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'b1111111}}) begin
            errors++; $display("FAIL reset_hex got %b exp all ones", {HEX3, HEX2, HEX1, HEX0});
        end
    endtask

    task automatic test_change();
        int base;
        do_reset();
        base = upd_total;
        digit(4'h1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy_first got %b exp 1", busy); end
        digit(4'h2); digit(4'h3); digit(4'h4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy_new got %b exp 1", busy); end
        code4(16'h5678);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy_conf got %b exp 1", busy); end
        checks++; if (code_o !== 16'h1234) begin errors++; $display("FAIL chg_code_pre got %h exp 1234", code_o); end
        code4(16'h5678);
        checks++; if (code_o !== 16'h5678) begin errors++; $display("FAIL chg_code got %h exp 5678", code_o); end
        checks++; if (upd_total - base != 1) begin errors++; $display("FAIL chg_upd_cycles got %0d exp 1", upd_total - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_busy_ok got %b exp 0", busy); end
        digit(4'h7);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_ok_ignores got %b exp 0", busy); end
        cancel();
        digit(4'h5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_back_old got %b exp 1", busy); end
        cancel();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_cancel got %b exp 0", busy); end
    endtask

    task automatic test_err_old();
        int base;
        do_reset();
        base = upd_total;
        code4(16'h9999);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL errold_busy got %b exp 0", busy); end
        checks++; if (code_o !== 16'h1234) begin errors++; $display("FAIL errold_code got %h exp 1234", code_o); end
        checks++; if (upd_total != base) begin errors++; $display("FAIL errold_upd got %0d exp 0", upd_total - base); end
        digit(4'h1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL errold_ignores got %b exp 0", busy); end
        cancel();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL errold_cancel got %b exp 0", busy); end
        digit(4'h1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL errold_back_old got %b exp 1", busy); end
        cancel();
    endtask

    task automatic test_conf_mismatch();
        int base;
        do_reset();
        base = upd_total;
        code4(16'h1234);
        code4(16'h5678);
        code4(16'h5679);
        checks++; if (code_o !== 16'h1234) begin errors++; $display("FAIL confmis_code got %h exp 1234", code_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL confmis_busy got %b exp 0", busy); end
        checks++; if (upd_total != base) begin errors++; $display("FAIL confmis_upd got %0d exp 0", upd_total - base); end
        cancel();
    endtask

    task automatic test_cancel();
        do_reset();
        digit(4'h1); digit(4'h2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL can_busy_pre got %b exp 1", busy); end
        cancel();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL can_busy got %b exp 0", busy); end
        SW = 4'h1;
        KEY = 2'b00;
        clks(10);
        KEY = 2'b11;
        clks(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL can_simul got %b exp 0", busy); end
        code4(16'h1234);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL can_reach_new got %b exp 1", busy); end
        code4(16'hABCD);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL can_reach_conf got %b exp 1", busy); end
        cancel();
    endtask

    task automatic test_async_reset();
        do_reset();
        code4(16'h1234); code4(16'h5678); code4(16'h5678);
        checks++; if (code_o !== 16'h5678) begin errors++; $display("FAIL arst_pre got %h exp 5678", code_o); end
        cancel();
        code4(16'h5678); code4(16'h1111);
        digit(4'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (code_o !== 16'h1234) begin errors++; $display("FAIL arst_code got %h exp 1234", code_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
        clks(3);
        rst_n = 1'b1;
        clks(3);
        code4(16'h1234);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_old_accept got %b exp 1", busy); end
        cancel();
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_change();
                test_err_old();
                test_conf_mismatch();
                test_cancel();
                test_async_reset();
            end
            begin
                #2000000;
                errors++;
                $display("FAIL timeout reached limit exp completion");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pass_set.md
Name: pass_set

Overview:
- Password programming block for the 4-digit switch/key lock. It is the writer side of the stored code that the lock checker reads.
- User enters the current code, then a new code, then the new code again to confirm. On a match, the block updates the stored code and drives it to the checker on `code_o`.
- Board-facing I/O matches the lock: `SW` digit entry, active-low `KEY` buttons, active-low 7-segment `HEX` digits.

Parameters:
- `DIGITS`, 4, number of code digits.
- `DW`, 4, bits per digit (width of `SW`).
- `DEFAULT_CODE`, 16'h1234, stored code after reset; first digit in bits [15:12].

Ports:
- `clk`, input, 1, system clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `SW`, input, 4, digit value to enter.
- `KEY`, input, 2, active-low buttons: `KEY[0]` = enter digit, `KEY[1]` = cancel/acknowledge.
- `code_o`, output, 16, stored password for the checker.
- `code_upd`, output, 1, one-cycle pulse when `code_o` changes.
- `busy`, output, 1, high while any digit of the current sequence has been entered.
- `HEX0`, output, [0:6], active-low segments a..g; index 0 = a.
- `HEX1`, output, [0:6], same encoding.
- `HEX2`, output, [0:6], same encoding.
- `HEX3`, output, [0:6], same encoding.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (`rst_n`).
  - While `rst_n`=0: `code_o`=`DEFAULT_CODE`, `code_upd`=0, `busy`=0, state=OLD, digit count=0, entry buffers=0, HEX blank (7'b1111111 each).
  - Async reset mid-sequence discards all entered digits and restores `DEFAULT_CODE`.
- Inputs:
  - `KEY[1:0]` and `SW` pass through a 2-FF synchronizer.
  - A press is the falling edge of a synchronized `KEY` bit. It yields a one-cycle pulse (`ent_p`, `can_p`).
  - If `KEY[0]` is first sampled 0 at edge N, `ent_p` is high in cycle N+2. The synchronized `SW` value is latched at the end of that cycle.
  - Holding a key gives exactly one pulse. Releasing gives none.
- Digits:
  - Digit k (0-based) goes to buffer bits [15-4k:12-4k].
  - Values 0-F are all accepted.
  - The digit counter is 0..3. On the 4th digit the sequence completes, the counter wraps to 0 and the state transitions on the same edge.
- FSM states: OLD, NEW, CONF, OK, ERR.
  - OLD: collect 4 digits; on completion, buffer==`code_o` -> NEW, else -> ERR.
  - NEW: collect 4 digits into `new_buf` -> CONF.
  - CONF: collect 4 digits; if equal to `new_buf`: `code_o`<=`new_buf`, `code_upd`=1 for that single following cycle, -> OK. Otherwise -> ERR with `code_o` unchanged.
  - OK/ERR: `ent_p` ignored; `can_p` -> OLD.
  - `can_p` in OLD/NEW/CONF: clear counter and buffers -> OLD, no code change.
- Simultaneous `ent_p` and `can_p`: cancel wins; the digit is not stored.
- `busy`=1 when the counter≠0, or when in state NEW or CONF.
- Writing a new code equal to the old one is legal: `code_upd` still pulses.

Optional Feature:
- Macro: `PASS_SET_HEX_EN`.
- Defined: registered HEX, updated one cycle after state/digit change.
  - OLD: HEX3='o' (1100010).
  - NEW: HEX3='n' (1101010).
  - CONF: HEX3='C' (0110001).
  - In OLD/NEW/CONF: HEX2 blank, HEX1 = digit count as hex, HEX0 = hex of synchronized `SW` (standard 0-F font, e.g. '1'=1001111).
  - OK: HEX3..HEX0 = "donE": d=1000010, o=1100010, n=1101010, E=0110000.
  - ERR: HEX3 blank, HEX2..HEX0 = "Err": E=0110000, r=1111010, r=1111010.
- Not defined: all HEX outputs constant 7'b1111111, and no display logic is synthesized.

Test Plan:
- Reset release, no keys -> `code_o`=16'h1234, `code_upd`=0, `busy`=0; HEX3=1100010 if EN.
- Enter 1,2,3,4 then 5,6,7,8 then 5,6,7,8 (each `KEY[0]` low 10 clk, then high 10 clk) -> `code_o`=16'h5678, `code_upd` high exactly 1 cycle, state OK.
- Enter 9,9,9,9 in OLD -> ERR, `code_o` stays 16'h1234, no `code_upd`; `KEY[1]` press -> OLD, `busy`=0.
- Old 1,2,3,4, new 5,6,7,8, confirm 5,6,7,9 -> ERR, `code_o`=16'h1234.
- Enter 1,2 then `KEY[1]`, then same-cycle `KEY[0]`+`KEY[1]` press -> counter=0, `busy`=0, no digit stored; a following 1,2,3,4 reaches NEW.
- Drive `rst_n`=0 for 3 clk during CONF after a successful earlier change to 16'h5678 -> `code_o`=16'h1234 immediately (asynchronous), state OLD.
